// File: rtl/mcu_bus_arbiter_pkg.sv
// Shared MCU bus map: address ranges, arbiter state encodings and owner encoding.
package mcu_bus_arbiter_pkg;

  localparam logic [15:0] MAP_RAM_TOP       = 16'h0FFF;
  localparam logic [15:0] MAP_PIO_BASE      = 16'hFB00;
  localparam logic [15:0] MAP_PIO_LAST      = 16'hFB0F;
  localparam logic [7:0]  MAP_UNMAPPED_DATA = 8'hFF;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

endpackage

// File: rtl/mcu_addr_decode.sv
// Combinational MCU address decode: RAM window, PIO window, everything else unmapped.
module mcu_addr_decode
  import mcu_bus_arbiter_pkg::*;
#(
  parameter logic [15:0] RAM_TOP  = MAP_RAM_TOP,
  parameter logic [15:0] PIO_BASE = MAP_PIO_BASE,
  parameter logic [15:0] PIO_LAST = MAP_PIO_LAST
) (
  input  logic [15:0] addr,
  output logic        sel_ram,
  output logic        sel_pio,
  output logic        unmapped
);

  assign sel_ram  = (addr <= RAM_TOP);
  assign sel_pio  = (addr >= PIO_BASE) && (addr <= PIO_LAST);
  assign unmapped = !(sel_ram || sel_pio);

endmodule

// File: rtl/mcu_bus_arbiter.sv
// Two-master MCU bus arbiter: round-robin (with CPU lock) IDLE->ACCESS->RESP sequencer,
// chip-enable decode and per-master read-data capture; each access takes exactly 3 cycles.
module mcu_bus_arbiter
  import mcu_bus_arbiter_pkg::*;
#(
  parameter logic [15:0] RAM_TOP       = MAP_RAM_TOP,
  parameter logic [15:0] PIO_BASE      = MAP_PIO_BASE,
  parameter logic [15:0] PIO_LAST      = MAP_PIO_LAST,
  parameter logic [7:0]  UNMAPPED_DATA = MAP_UNMAPPED_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_gnt,
  output logic        m0_ack,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_gnt,
  output logic        m1_ack,
  output logic [7:0]  m1_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  output logic        ce_ram,
  output logic        ce_pio,
  input  logic [7:0]  ram_rdata,
  input  logic [7:0]  pio_rdata,
  output logic        bus_err
);

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic        we_q, we_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic [7:0]  rdata0_q, rdata0_d;
  logic [7:0]  rdata1_q, rdata1_d;

  logic       win;
  logic       sel_ram, sel_pio, unmapped;
  logic       in_access, in_resp;
  logic [7:0] rsp_data;

  mcu_addr_decode #(
    .RAM_TOP  (RAM_TOP),
    .PIO_BASE (PIO_BASE),
    .PIO_LAST (PIO_LAST)
  ) u_decode (
    .addr     (bus_addr_q),
    .sel_ram  (sel_ram),
    .sel_pio  (sel_pio),
    .unmapped (unmapped)
  );

  // Round-robin on contention, except a locked CPU keeps the bus it just used.
  always_comb begin
    win = m0_req ? OWN_M0 : OWN_M1;
    if (m0_req && m1_req) begin
      win = (last_owner_q == OWN_M0 && !m0_lock) ? OWN_M1 : OWN_M0;
    end
  end

  assign rsp_data = unmapped ? UNMAPPED_DATA : (sel_ram ? ram_rdata : pio_rdata);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          owner_d     = win;
          we_d        = (win == OWN_M0) ? m0_we    : m1_we;
          bus_addr_d  = (win == OWN_M0) ? m0_addr  : m1_addr;
          bus_wdata_d = (win == OWN_M0) ? m0_wdata : m1_wdata;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        last_owner_d = owner_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (!we_q) begin
          if (owner_q == OWN_M0) rdata0_d = rsp_data;
          else                   rdata1_d = rsp_data;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_M1;
      last_owner_q <= OWN_M1;
      we_q         <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);

  assign m0_gnt = (in_access || in_resp) && (owner_q == OWN_M0);
  assign m1_gnt = (in_access || in_resp) && (owner_q == OWN_M1);
  assign m0_ack = in_resp && (owner_q == OWN_M0);
  assign m1_ack = in_resp && (owner_q == OWN_M1);

  // Target data only arrives in RESP, so it is passed through during ack and held afterwards.
  assign m0_rdata = (m0_ack && !we_q) ? rsp_data : rdata0_q;
  assign m1_rdata = (m1_ack && !we_q) ? rsp_data : rdata1_q;

  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign ce_ram    = in_access && sel_ram;
  assign ce_pio    = in_access && sel_pio;
  assign bus_we    = in_access && we_q && !unmapped;
  assign bus_re    = in_access && !we_q && !unmapped;
  assign bus_err   = in_resp && unmapped;

endmodule

// File: tb/tb_mcu_bus_arbiter.sv
// Scoreboard bench for mcu_bus_arbiter: transaction-level model predicts winner and data.
module tb_mcu_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_lock;
  logic [15:0] m0_addr;
  logic [7:0]  m0_wdata;
  logic        m0_gnt, m0_ack;
  logic [7:0]  m0_rdata;
  logic        m1_req, m1_we;
  logic [15:0] m1_addr;
  logic [7:0]  m1_wdata;
  logic        m1_gnt, m1_ack;
  logic [7:0]  m1_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we, bus_re, ce_ram, ce_pio, bus_err;
  logic [7:0]  ram_rdata, pio_rdata;

  always #5 clk = ~clk;

  mcu_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .ce_ram(ce_ram), .ce_pio(ce_pio), .ram_rdata(ram_rdata), .pio_rdata(pio_rdata),
    .bus_err(bus_err)
  );

  typedef struct {
    logic        vld;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  typedef struct {
    logic        own;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        is_ram;
    logic        is_pio;
    logic [7:0]  rdata;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  exp_t        cur;
  logic        have_cur = 1'b0;
  logic        mon_en   = 1'b1;
  logic [7:0]  held0    = 8'h00;
  logic [7:0]  held1    = 8'h00;
  txn_t        pend0, pend1;
  logic        last_own;
  logic [7:0]  shadow [logic [15:0]];
  logic [7:0]  tmem   [logic [15:0]];
  logic [15:0] bnd [6] = '{16'h0FFF, 16'h1000, 16'hFAFF, 16'hFB00, 16'hFB0F, 16'hFB10};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h96;
  endfunction

  function automatic txn_t mk(input logic v, input logic w, input logic [15:0] a,
                              input logic [7:0] d);
    txn_t t;
    t.vld = v; t.we = w; t.addr = a; t.wdata = d;
    return t;
  endfunction

  function automatic logic [15:0] rand_addr();
    int k;
    k = $urandom_range(0, 4);
    case (k)
      0, 1:    return 16'($urandom_range(0, 4095));
      2:       return 16'hFB00 + 16'($urandom_range(0, 15));
      3:       return bnd[$urandom_range(0, 5)];
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic txn_t rand_txn(input logic v);
    return mk(v, 1'($urandom), rand_addr(), 8'($urandom));
  endfunction

  // RAM and PIO targets: strobe sampled on the clock edge, data one cycle later.
  always @(posedge clk) begin
    if ((ce_ram || ce_pio) && bus_we) tmem[bus_addr] = bus_wdata;
    if (ce_ram && bus_re) ram_rdata <= tmem.exists(bus_addr) ? tmem[bus_addr] : init_val(bus_addr);
    if (ce_pio && bus_re) pio_rdata <= tmem.exists(bus_addr) ? tmem[bus_addr] : init_val(bus_addr);
  end

  // Reference model: one arbitration per round, then the fixed 3-cycle access.
  task automatic do_round(input txn_t n0, input txn_t n1, input logic lock);
    exp_t e;
    txn_t t;
    logic w;
    if (!pend0.vld) pend0 = n0;
    if (!pend1.vld) pend1 = n1;
    m0_req = pend0.vld; m0_we = pend0.we; m0_addr = pend0.addr; m0_wdata = pend0.wdata;
    m1_req = pend1.vld; m1_we = pend1.we; m1_addr = pend1.addr; m1_wdata = pend1.wdata;
    m0_lock = lock;
    if (!pend0.vld && !pend1.vld) begin
      @(posedge clk); #1;
      return;
    end
    if (pend0.vld && pend1.vld) w = (last_own == 1'b0 && lock) ? 1'b0 : ~last_own;
    else                        w = pend1.vld;
    t = w ? pend1 : pend0;
    e.own = w; e.we = t.we; e.addr = t.addr; e.wdata = t.wdata;
    e.is_ram = (t.addr <= 16'h0FFF);
    e.is_pio = (t.addr >= 16'hFB00) && (t.addr <= 16'hFB0F);
    e.rdata  = 8'hFF;
    if (e.is_ram || e.is_pio) begin
      if (t.we) shadow[t.addr] = t.wdata;
      else      e.rdata = shadow.exists(t.addr) ? shadow[t.addr] : init_val(t.addr);
    end
    exp_q.push_back(e);
    last_own = w;
    if (w) pend1.vld = 1'b0;
    else   pend0.vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: ACCESS is a grant without ack, RESP is the ack cycle.
  always @(negedge clk) begin
    chk("mutex", {29'd0, m0_gnt & m1_gnt, m0_ack & m1_ack, ce_ram & ce_pio}, 32'd0);
    if (mon_en) begin
      if ((m0_gnt || m1_gnt) && !(m0_ack || m1_ack)) begin
        chk("ack_before_next_access", {31'd0, have_cur}, 32'd0);
        chk("grant_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          chk("gnt_owner", {30'd0, m0_gnt, m1_gnt}, cur.own ? 32'd1 : 32'd2);
          chk("access_ce_strobe", {28'd0, ce_ram, ce_pio, bus_we, bus_re},
              {28'd0, cur.is_ram, cur.is_pio,
               cur.we & (cur.is_ram | cur.is_pio), ~cur.we & (cur.is_ram | cur.is_pio)});
          chk("bus_addr", {16'd0, bus_addr}, {16'd0, cur.addr});
          if (cur.we) chk("bus_wdata", {24'd0, bus_wdata}, {24'd0, cur.wdata});
          chk("access_no_err", {31'd0, bus_err}, 32'd0);
        end
      end else if (m0_ack || m1_ack) begin
        chk("resp_after_access", {31'd0, have_cur}, 32'd1);
        if (have_cur) begin
          chk("ack_owner", {30'd0, m0_ack, m1_ack}, cur.own ? 32'd1 : 32'd2);
          chk("resp_gnt", {30'd0, m0_gnt, m1_gnt}, cur.own ? 32'd1 : 32'd2);
          chk("resp_quiet", {28'd0, ce_ram, ce_pio, bus_we, bus_re}, 32'd0);
          chk("bus_err", {31'd0, bus_err}, {31'd0, !(cur.is_ram || cur.is_pio)});
          if (!cur.we) begin
            if (cur.own) held1 = cur.rdata;
            else         held0 = cur.rdata;
          end
          chk("m0_rdata", {24'd0, m0_rdata}, {24'd0, held0});
          chk("m1_rdata", {24'd0, m1_rdata}, {24'd0, held1});
          have_cur = 1'b0;
        end
      end else begin
        chk("ack_missing", {31'd0, have_cur}, 32'd0);
        have_cur = 1'b0;
        chk("idle_quiet", {27'd0, ce_ram, ce_pio, bus_we, bus_re, bus_err}, 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b0;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    pend0 = mk(0, 0, 0, 0); pend1 = mk(0, 0, 0, 0);
    last_own = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {23'd0, m0_gnt, m1_gnt, m0_ack, m1_ack, bus_we, bus_re,
                       ce_ram, ce_pio, bus_err}, 32'd0);
    chk("reset_rdata", {16'd0, m0_rdata, m1_rdata}, 32'd0);
    chk("reset_bus", {8'd0, bus_addr, bus_wdata}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed: basic read/write, PIO write, unmapped, address-map edges.
    do_round(mk(0, 0, 0, 0), mk(1, 1, 16'h0010, 8'h5A), 1'b0);
    do_round(mk(1, 0, 16'h0010, 0), mk(0, 0, 0, 0), 1'b0);
    do_round(mk(0, 0, 0, 0), mk(1, 1, 16'hFB03, 8'hC3), 1'b0);
    do_round(mk(1, 0, 16'hFB03, 0), mk(0, 0, 0, 0), 1'b0);
    do_round(mk(1, 0, 16'h8000, 0), mk(0, 0, 0, 0), 1'b0);
    do_round(mk(0, 0, 0, 0), mk(1, 1, 16'h8000, 8'h11), 1'b0);
    for (int i = 0; i < 6; i++) do_round(mk(1, 0, bnd[i], 0), mk(0, 0, 0, 0), 1'b0);

    // Sustained contention, then the same with the CPU locking its first three accesses.
    for (int i = 0; i < 6; i++) do_round(rand_txn(1'b1), rand_txn(1'b1), 1'b0);
    for (int i = 0; i < 6; i++) do_round(rand_txn(1'b1), rand_txn(1'b1), i < 3);

    for (int i = 0; i < 400; i++)
      do_round(rand_txn($urandom_range(0, 2) != 0), rand_txn($urandom_range(0, 2) != 0),
               $urandom_range(0, 3) == 0);
    for (int i = 0; i < 3; i++) do_round(mk(0, 0, 0, 0), mk(0, 0, 0, 0), 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_queue", exp_q.size(), 32'd0);
    chk("drain_open", {31'd0, have_cur}, 32'd0);

    // Reset during an m1 write's ACCESS cycle.
    @(posedge clk); #1;
    mon_en = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0020; m1_wdata = 8'h77;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_in_access", {30'd0, m1_gnt, bus_we}, 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_ctrl", {23'd0, m0_gnt, m1_gnt, m0_ack, m1_ack, bus_we, bus_re,
                         ce_ram, ce_pio, bus_err}, 32'd0);
    chk("rst_mid_data", {16'd0, m0_rdata, m1_rdata}, 32'd0);
    chk("rst_mid_bus", {8'd0, bus_addr, bus_wdata}, 32'd0);
    m1_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {28'd0, m0_gnt, m1_gnt, m0_ack, m1_ack}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
